// File: rtl/pc_npc_sequencer.sv
// Fetch-stage PC/nPC sequencer with SPARC-style delayed branching.
// Latency: a taken branch reaches pc_out two edges after br_valid (delay slot first).
// Backpressure: le=0 stalls PC/nPC; one branch is buffered, later ones set br_overrun.
// Optional feature macro PCSEQ_ANNUL_EN adds br_annul and a live squash_out.
module pc_npc_sequencer #(
  parameter int AW     = 9,
  parameter int RST_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          le,
  input  logic          br_valid,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
`ifdef PCSEQ_ANNUL_EN
  input  logic          br_annul,
`endif
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] npc_out,
  output logic          fetch_valid,
  output logic          in_delay_slot,
  output logic          squash_out,
  output logic          pending_br,
  output logic          br_overrun
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL} state_t;

  localparam logic [AW-1:0] RST_PC_V = AW'(RST_PC);
  localparam logic [AW-1:0] STEP     = AW'(4);
  localparam logic [AW-1:0] ALIGN    = ~AW'(3);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, npc_q, npc_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic          in_delay_q, in_delay_d;
  logic          pend_q, pend_d;
  logic          overrun_q, overrun_d;
  logic          pend_taken_q, pend_taken_d;
  logic [AW-1:0] pend_tgt_q, pend_tgt_d;
  logic [AW-1:0] tgt_aligned;
  logic          eff_vld, eff_taken, redirect;
  logic [AW-1:0] eff_tgt;
`ifdef PCSEQ_ANNUL_EN
  logic          squash_q, squash_d;
  logic          pend_annul_q, pend_annul_d;
  logic          eff_annul;
`endif

  // Branch targets are word aligned; low two bits are dropped here.
  assign tgt_aligned = br_target & ALIGN;

  // Next-state logic: boot handshake, stall capture, and advance/redirect.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    npc_d         = npc_q;
    fetch_valid_d = fetch_valid_q;
    in_delay_d    = in_delay_q;
    pend_d        = pend_q;
    overrun_d     = overrun_q;
    pend_taken_d  = pend_taken_q;
    pend_tgt_d    = pend_tgt_q;
    eff_vld       = 1'b0;
    eff_taken     = 1'b0;
    eff_tgt       = '0;
    redirect      = 1'b0;
`ifdef PCSEQ_ANNUL_EN
    squash_d      = squash_q;
    pend_annul_d  = pend_annul_q;
    eff_annul     = 1'b0;
`endif
    case (state_q)
      S_BOOT: begin
        // First cycle out of reset: start fetching, branches are ignored.
        state_d       = S_RUN;
        fetch_valid_d = 1'b1;
      end
      default: begin
        state_d = le ? S_RUN : S_STALL;
        if (!le) begin
          if (br_valid) begin
            if (pend_q) begin
              overrun_d = 1'b1;
            end else begin
              pend_d       = 1'b1;
              pend_taken_d = br_taken;
              pend_tgt_d   = tgt_aligned;
`ifdef PCSEQ_ANNUL_EN
              pend_annul_d = br_annul;
`endif
            end
          end
        end else begin
          // A buffered branch has priority; a live one on the same edge is dropped.
          if (pend_q) begin
            eff_vld   = 1'b1;
            eff_taken = pend_taken_q;
            eff_tgt   = pend_tgt_q;
`ifdef PCSEQ_ANNUL_EN
            eff_annul = pend_annul_q;
`endif
            pend_d    = 1'b0;
            if (br_valid) overrun_d = 1'b1;
          end else if (br_valid) begin
            eff_vld   = 1'b1;
            eff_taken = br_taken;
            eff_tgt   = tgt_aligned;
`ifdef PCSEQ_ANNUL_EN
            eff_annul = br_annul;
`endif
          end
          redirect   = eff_vld & eff_taken;
          pc_d       = npc_q;
          npc_d      = redirect ? eff_tgt : npc_q + STEP;
          in_delay_d = redirect;
`ifdef PCSEQ_ANNUL_EN
          // Only an untaken annulling branch kills its delay slot.
          squash_d   = eff_vld & ~eff_taken & eff_annul;
`endif
        end
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RST_PC_V;
      npc_q         <= RST_PC_V + STEP;
      fetch_valid_q <= 1'b0;
      in_delay_q    <= 1'b0;
      pend_q        <= 1'b0;
      overrun_q     <= 1'b0;
      pend_taken_q  <= 1'b0;
      pend_tgt_q    <= '0;
`ifdef PCSEQ_ANNUL_EN
      squash_q      <= 1'b0;
      pend_annul_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      fetch_valid_q <= fetch_valid_d;
      in_delay_q    <= in_delay_d;
      pend_q        <= pend_d;
      overrun_q     <= overrun_d;
      pend_taken_q  <= pend_taken_d;
      pend_tgt_q    <= pend_tgt_d;
`ifdef PCSEQ_ANNUL_EN
      squash_q      <= squash_d;
      pend_annul_q  <= pend_annul_d;
`endif
    end
  end

  assign pc_out        = pc_q;
  assign npc_out       = npc_q;
  assign fetch_valid   = fetch_valid_q;
  assign in_delay_slot = in_delay_q;
  assign pending_br    = pend_q;
  assign br_overrun    = overrun_q;
`ifdef PCSEQ_ANNUL_EN
  assign squash_out    = squash_q;
`else
  assign squash_out    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Bench for pc_npc_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_pc_npc_sequencer;
  localparam int AW   = 9;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst, le, bv, bt, bann;
  logic [AW-1:0] btgt;
  logic [AW-1:0] pc_out, npc_out;
  logic          fetch_valid, in_delay_slot, squash_out, pending_br, br_overrun;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  int m_pc, m_npc;
  bit m_boot, m_fv, m_delay, m_squash, m_pend, m_ovr;
  bit p_taken, p_annul;
  int p_tgt;

`ifdef PCSEQ_ANNUL_EN
  localparam bit ANNUL = 1'b1;
`else
  localparam bit ANNUL = 1'b0;
`endif

  pc_npc_sequencer #(.AW(AW), .RST_PC(0)) dut (
    .clk(clk), .reset(rst), .le(le), .br_valid(bv), .br_taken(bt),
    .br_target(btgt),
`ifdef PCSEQ_ANNUL_EN
    .br_annul(bann),
`endif
    .pc_out(pc_out), .npc_out(npc_out), .fetch_valid(fetch_valid),
    .in_delay_slot(in_delay_slot), .squash_out(squash_out),
    .pending_br(pending_br), .br_overrun(br_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural effect of one clock edge, from the block's rules.
  task automatic model_edge();
    bit have, t, a;
    int tg;
    if (rst) begin
      m_pc = 0; m_npc = 4; m_boot = 1; m_fv = 0; m_delay = 0;
      m_squash = 0; m_pend = 0; m_ovr = 0;
      return;
    end
    if (m_boot) begin
      m_boot = 0; m_fv = 1;
      return;
    end
    if (!le) begin
      if (bv) begin
        if (m_pend) m_ovr = 1;
        else begin m_pend = 1; p_taken = bt; p_tgt = int'(btgt); p_annul = bann; end
      end
      return;
    end
    have = 0; t = 0; a = 0; tg = 0;
    if (m_pend) begin
      have = 1; t = p_taken; tg = p_tgt; a = p_annul; m_pend = 0;
      if (bv) m_ovr = 1;
    end else if (bv) begin
      have = 1; t = bt; tg = int'(btgt); a = bann;
    end
    m_pc = m_npc;
    if (have && t) begin
      m_npc = (tg / 4) * 4;
      m_delay = 1;
    end else begin
      m_npc = (m_npc + 4) % (MASK + 1);
      m_delay = 0;
    end
    m_squash = ANNUL && have && !t && a;
  endtask

  task automatic compare_all();
    chk("pc", 32'(pc_out), m_pc);
    chk("npc", 32'(npc_out), m_npc);
    chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    chk("in_delay_slot", 32'(in_delay_slot), 32'(m_delay));
    chk("squash_out", 32'(squash_out), 32'(m_squash));
    chk("pending_br", 32'(pending_br), 32'(m_pend));
    chk("br_overrun", 32'(br_overrun), 32'(m_ovr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    bv = 0; bt = 0; btgt = '0; bann = 0;
  endtask

  task automatic branch(input bit taken, input int tgt, input bit annul);
    bv = 1; bt = taken; btgt = AW'(tgt); bann = annul;
  endtask

  initial begin
    rst = 1; le = 1; idle();
    step();
    chk("rst_pc", 32'(pc_out), 0);
    chk("rst_fv", 32'(fetch_valid), 0);
    rst = 0;
    step();
    chk("boot_pc", 32'(pc_out), 0);
    chk("boot_fv", 32'(fetch_valid), 1);
    step(); chk("seq_pc4", 32'(pc_out), 32'h4);
    step(); chk("seq_pc8", 32'(pc_out), 32'h8);
    step(); chk("seq_pcC", 32'(pc_out), 32'hC);
    step(); chk("seq_pc10", 32'(pc_out), 32'h10);

    // taken branch: delay slot then target
    branch(1, 'h40, 0);
    step(); idle();
    chk("br_delay_pc", 32'(pc_out), 32'h14);
    chk("br_delay_flag", 32'(in_delay_slot), 1);
    step(); chk("br_tgt_pc", 32'(pc_out), 32'h40);
    step(); chk("br_tgt_next", 32'(pc_out), 32'h44);

    // branch captured during a stall
    le = 0; branch(1, 'h83, 0);
    step(); idle();
    step(); step();
    chk("stall_pc_hold", 32'(pc_out), 32'h44);
    chk("stall_pending", 32'(pending_br), 1);
    le = 1;
    step();
    chk("pend_delay_pc", 32'(pc_out), 32'h48);
    chk("pend_cleared", 32'(pending_br), 0);
    step(); chk("pend_tgt_pc", 32'(pc_out), 32'h80);

    // overrun: second branch during stall is dropped
    le = 0; branch(1, 'h100, 0);
    step(); branch(1, 'h1F8, 0);
    step(); idle();
    chk("overrun_set", 32'(br_overrun), 1);
    le = 1;
    step(); step();
    chk("overrun_first_wins", 32'(pc_out), 32'h100);

    // wrap at top of address space
    rst = 1; step(); rst = 0; step();
    chk("ovr_cleared", 32'(br_overrun), 0);
    branch(1, 'h1F4, 0);
    step(); idle();
    step(); step();
    chk("wrap_1f8", 32'(pc_out), 32'h1F8);
    step(); chk("wrap_1fc", 32'(pc_out), 32'h1FC);
    step(); chk("wrap_000", 32'(pc_out), 32'h000);
    step(); chk("wrap_004", 32'(pc_out), 32'h004);

`ifdef PCSEQ_ANNUL_EN
    branch(0, 'h20, 1);
    step(); idle();
    chk("annul_untaken_sq", 32'(squash_out), 1);
    step(); chk("annul_untaken_clr", 32'(squash_out), 0);
    branch(1, 'h20, 1);
    step(); idle();
    chk("annul_taken_sq", 32'(squash_out), 0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      le   = ($urandom_range(0, 99) < 75);
      bv   = ($urandom_range(0, 99) < 25);
      bt   = $urandom_range(0, 1) == 1;
      bann = $urandom_range(0, 1) == 1;
      btgt = AW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
